// File: rtl/pattern_sequencer_pkg.sv
// Shared definitions for the pattern sequencer: FSM state encoding and
// word-update mode codes, also used by the testbench.
package pattern_sequencer_pkg;

   // Two-bit encoding leaves 2'b11 unused; the FSM treats it as a fault and
   // returns to WAIT_REQ on the next tick.
   typedef enum logic [1:0] {
      WAIT_REQ = 2'b00,
      SEND     = 2'b01,
      RELEASE  = 2'b10
   } state_t;

   // Rules for advancing the data word when a transfer completes.
   localparam logic [1:0] MODE_INC   = 2'd0;
   localparam logic [1:0] MODE_DEC   = 2'd1;
   localparam logic [1:0] MODE_WALK  = 2'd2;
   localparam logic [1:0] MODE_CONST = 2'd3;

endpackage

// File: rtl/pattern_sequencer_tick_divider.sv
// Free-running clock-enable generator: one-cycle tick every TICK_DIV cycles
// of clk_raw. Kept standalone so the UART clock logic can reuse it.
module tick_divider #(
   parameter int TICK_DIV = 1160
) (
   input  logic clk_raw,
   input  logic reset,
   output logic tick
);

   // A divide-by-one still needs a one-bit counter that sits at zero.
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] div_cnt;

   assign tick = (div_cnt == LAST);

   // Count 0..TICK_DIV-1 and wrap; reset restarts the count from zero.
   always_ff @(posedge clk_raw) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (div_cnt == LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: produces one data word per request, hands it to the
// transmitter over a sent/received handshake, and advances the word by the
// selected mode. Supports free-running auto mode, an acknowledge timeout
// with a sticky error flag, and a wrapping transfer counter.
module pattern_sequencer
   import pattern_sequencer_pkg::*;
#(
   parameter int          WIDTH    = 8,
   parameter int unsigned START    = 32'h40,
   parameter int          TICK_DIV = 1160,
   parameter int          TIMEOUT  = 255,
   parameter int          CNT_W    = 16
) (
   input  logic             clk_raw,
   input  logic             reset,
   input  logic             step,
   input  logic             auto_en,
   input  logic [1:0]       mode,
   input  logic             received,
   output logic [WIDTH-1:0] data,
   output logic             sent,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] count
);

   // Reset value of the word, truncated or zero-extended to WIDTH.
   localparam logic [WIDTH-1:0] START_W = START[WIDTH-1:0];

   // The timeout counter only needs to reach TIMEOUT-1; a disabled timeout
   // (TIMEOUT=0) still gets a one-bit counter that is never compared.
   localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam bit            TO_EN   = (TIMEOUT != 0);

   state_t           state;
   logic [TW-1:0]    to_cnt;
   logic [WIDTH-1:0] next_word;
   logic             tick;
   logic             req;
   logic             release_ok;

   tick_divider #(
      .TICK_DIV(TICK_DIV)
   ) u_div (
      .clk_raw(clk_raw),
      .reset  (reset),
      .tick   (tick)
   );

   // Auto mode makes a request every time the FSM is idle; otherwise the
   // button level is the request.
   assign req = auto_en | step;

   // Leaving RELEASE needs the button released (unless in auto mode) and the
   // acknowledge dropped, so a held button or stuck acknowledge cannot cause
   // a second send of the same press.
   assign release_ok = (auto_en | ~step) & ~received;

   // Next word per mode; walking-one reseeds to 1 whenever the word is not
   // exactly one-hot so it always recovers into a clean walking pattern.
   always_comb begin
      next_word = data;
      case (mode)
         MODE_INC:  next_word = data + WIDTH'(1);
         MODE_DEC:  next_word = data - WIDTH'(1);
         MODE_WALK: next_word = $onehot(data) ? {data[WIDTH-2:0], data[WIDTH-1]}
                                              : WIDTH'(1);
         default:   next_word = data;
      endcase
   end

   // Handshake FSM with registered outputs; it only moves on divider ticks,
   // and every register holds its value between ticks.
   always_ff @(posedge clk_raw) begin
      if (reset) begin
         state  <= WAIT_REQ;
         data   <= START_W;
         sent   <= 1'b0;
         busy   <= 1'b0;
         err    <= 1'b0;
         count  <= '0;
         to_cnt <= '0;
      end else if (tick) begin
         case (state)
            WAIT_REQ: begin
               to_cnt <= '0;
               if (req) begin
                  state <= SEND;
                  sent  <= 1'b1;
                  busy  <= 1'b1;
               end
            end

            SEND: begin
               if (received) begin
                  state  <= RELEASE;
                  sent   <= 1'b0;
                  err    <= 1'b0;
                  count  <= count + CNT_W'(1);
                  to_cnt <= '0;
               end else if (TO_EN && (to_cnt == TO_LAST)) begin
                  state  <= WAIT_REQ;
                  sent   <= 1'b0;
                  busy   <= 1'b0;
                  err    <= 1'b1;
                  to_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end

            RELEASE: begin
               if (release_ok) begin
                  state <= WAIT_REQ;
                  busy  <= 1'b0;
                  data  <= next_word;
               end
            end

            default: begin
               state  <= WAIT_REQ;
               sent   <= 1'b0;
               busy   <= 1'b0;
               to_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed testbench for pattern_sequencer (TICK_DIV=4, TIMEOUT=3, WIDTH=8).
// A second instance with START=0 shares all inputs to cover the
// decrement wrap from zero.
module tb_pattern_sequencer;
   import pattern_sequencer_pkg::*;

   logic        clk_raw      = 1'b0;
   logic        reset        = 1'b1;
   logic        step         = 1'b0;
   logic        auto_en      = 1'b0;
   logic [1:0]  mode         = 2'd0;
   logic        received_drv = 1'b0;
   logic        loopback     = 1'b0;
   logic        received;

   logic [7:0]  data, data0;
   logic        sent, sent0, busy, busy0, err, err0;
   logic [15:0] count, count0;

   int checks     = 0;
   int failures   = 0;
   int sent_rises = 0;
   logic prev_sent = 1'b0;

   // The loopback transmitter acknowledges as soon as it sees sent.
   assign received = loopback ? sent : received_drv;

   pattern_sequencer #(
      .WIDTH(8), .START(32'h40), .TICK_DIV(4), .TIMEOUT(3), .CNT_W(16)
   ) dut (
      .clk_raw(clk_raw), .reset(reset), .step(step), .auto_en(auto_en),
      .mode(mode), .received(received), .data(data), .sent(sent),
      .busy(busy), .err(err), .count(count)
   );

   pattern_sequencer #(
      .WIDTH(8), .START(32'h00), .TICK_DIV(4), .TIMEOUT(3), .CNT_W(16)
   ) dut0 (
      .clk_raw(clk_raw), .reset(reset), .step(step), .auto_en(auto_en),
      .mode(mode), .received(received), .data(data0), .sent(sent0),
      .busy(busy0), .err(err0), .count(count0)
   );

   // 10-unit clock period.
   always #5 clk_raw = ~clk_raw;

   // Count rising edges of sent to detect double sends.
   always @(posedge clk_raw) begin
      prev_sent <= sent;
      if (sent && !prev_sent) sent_rises <= sent_rises + 1;
   end

   // Advance to just past the next FSM tick edge (ticks every 4 cycles
   // after the reset edge).
   task automatic tick();
      repeat (4) @(posedge clk_raw);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk_raw);
      #1;
      reset = 1'b0;
   endtask

   // One complete acknowledged transfer from WAIT_REQ back to WAIT_REQ.
   task automatic do_transfer(input logic [1:0] m);
      mode = m;
      step = 1'b1;
      tick();
      received_drv = 1'b1;
      tick();
      step = 1'b0;
      received_drv = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (data !== 8'h40) begin failures++; $display("[TB] FAIL reset_data got=%h exp=%h", data, 8'h40); end
      checks++; if (sent !== 1'b0) begin failures++; $display("[TB] FAIL reset_sent got=%b exp=0", sent); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
      checks++; if (count !== 16'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
      checks++; if (data0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_data0 got=%h exp=00", data0); end
      checks++; if ({sent0, busy0, err0} !== 3'b000 || count0 !== 16'd0) begin failures++; $display("[TB] FAIL reset_dut0 got=%b%b%b/%0d exp=000/0", sent0, busy0, err0, count0); end
      tick();
      checks++; if (sent !== 1'b0) begin failures++; $display("[TB] FAIL idle_sent got=%b exp=0", sent); end
   endtask

   task automatic test_single_step();
      int base;
      base = sent_rises;
      step = 1'b1;
      tick();
      checks++; if (sent !== 1'b1) begin failures++; $display("[TB] FAIL step_sent got=%b exp=1", sent); end
      checks++; if (data !== 8'h40) begin failures++; $display("[TB] FAIL step_data got=%h exp=40", data); end
      tick();
      checks++; if (sent !== 1'b1) begin failures++; $display("[TB] FAIL step_wait_sent got=%b exp=1", sent); end
      received_drv = 1'b1;
      tick();
      checks++; if (sent !== 1'b0) begin failures++; $display("[TB] FAIL step_ack_sent got=%b exp=0", sent); end
      checks++; if (count !== 16'd1) begin failures++; $display("[TB] FAIL step_count got=%0d exp=1", count); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL step_busy got=%b exp=1", busy); end
      tick();
      checks++; if (data !== 8'h40) begin failures++; $display("[TB] FAIL step_hold_data got=%h exp=40", data); end
      step = 1'b0;
      received_drv = 1'b0;
      tick();
      checks++; if (data !== 8'h41) begin failures++; $display("[TB] FAIL step_next_data got=%h exp=41", data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL step_idle_busy got=%b exp=0", busy); end
      checks++; if (sent_rises - base !== 1) begin failures++; $display("[TB] FAIL step_rises got=%0d exp=1", sent_rises - base); end
   endtask

   task automatic test_held_step();
      int base;
      base = sent_rises;
      step = 1'b1;
      tick();
      received_drv = 1'b1;
      tick();
      repeat (3) begin
         received_drv = 1'b0;
         tick();
         received_drv = 1'b1;
         tick();
      end
      checks++; if (count !== 16'd2) begin failures++; $display("[TB] FAIL held_count got=%0d exp=2", count); end
      checks++; if (sent_rises - base !== 1) begin failures++; $display("[TB] FAIL held_rises got=%0d exp=1", sent_rises - base); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL held_busy got=%b exp=1", busy); end
      checks++; if (data !== 8'h41) begin failures++; $display("[TB] FAIL held_data got=%h exp=41", data); end
      step = 1'b0;
      received_drv = 1'b0;
      tick();
      checks++; if (data !== 8'h42) begin failures++; $display("[TB] FAIL held_release_data got=%h exp=42", data); end
      step = 1'b1;
      tick();
      checks++; if (sent !== 1'b1 || sent_rises - base !== 1) begin failures++; $display("[TB] FAIL held_second_send got=%b/%0d exp=1/1", sent, sent_rises - base); end
      received_drv = 1'b1;
      tick();
      step = 1'b0;
      received_drv = 1'b0;
      tick();
      checks++; if (count !== 16'd3) begin failures++; $display("[TB] FAIL held_count2 got=%0d exp=3", count); end
      checks++; if (data !== 8'h43) begin failures++; $display("[TB] FAIL held_data2 got=%h exp=43", data); end
      checks++; if (sent_rises - base !== 2) begin failures++; $display("[TB] FAIL held_rises2 got=%0d exp=2", sent_rises - base); end
   endtask

   task automatic test_modes();
      do_reset();
      do_transfer(MODE_DEC);
      checks++; if (data0 !== 8'hFF) begin failures++; $display("[TB] FAIL dec_wrap got=%h exp=ff", data0); end
      checks++; if (data !== 8'h3F) begin failures++; $display("[TB] FAIL dec_data got=%h exp=3f", data); end
      checks++; if (count0 !== 16'd1) begin failures++; $display("[TB] FAIL dec_count got=%0d exp=1", count0); end
      do_reset();
      do_transfer(MODE_WALK);
      checks++; if (data !== 8'h80) begin failures++; $display("[TB] FAIL walk_40 got=%h exp=80", data); end
      do_transfer(MODE_WALK);
      checks++; if (data !== 8'h01) begin failures++; $display("[TB] FAIL walk_80 got=%h exp=01", data); end
      do_reset();
      do_transfer(MODE_INC);
      do_transfer(MODE_WALK);
      checks++; if (data !== 8'h01) begin failures++; $display("[TB] FAIL walk_41 got=%h exp=01", data); end
      do_transfer(MODE_CONST);
      checks++; if (data !== 8'h01) begin failures++; $display("[TB] FAIL const got=%h exp=01", data); end
      // Mode changed after the word was sent: the exit-time mode applies.
      mode = MODE_INC;
      step = 1'b1;
      tick();
      received_drv = 1'b1;
      tick();
      mode = MODE_DEC;
      step = 1'b0;
      received_drv = 1'b0;
      tick();
      checks++; if (data !== 8'h00) begin failures++; $display("[TB] FAIL mode_late got=%h exp=00", data); end
      checks++; if (data0 !== 8'h01) begin failures++; $display("[TB] FAIL mode_seq0 got=%h exp=01", data0); end
   endtask

   task automatic test_timeout();
      do_reset();
      mode = MODE_INC;
      step = 1'b1;
      tick();
      checks++; if (sent !== 1'b1) begin failures++; $display("[TB] FAIL to_enter got=%b exp=1", sent); end
      step = 1'b0;
      tick();
      tick();
      checks++; if (sent !== 1'b1 || err !== 1'b0) begin failures++; $display("[TB] FAIL to_pending got=%b/%b exp=1/0", sent, err); end
      tick();
      checks++; if (sent !== 1'b0) begin failures++; $display("[TB] FAIL to_sent got=%b exp=0", sent); end
      checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL to_err got=%b exp=1", err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL to_busy got=%b exp=0", busy); end
      checks++; if (data !== 8'h40 || count !== 16'd0) begin failures++; $display("[TB] FAIL to_unchanged got=%h/%0d exp=40/0", data, count); end
      // Retry the same word; acknowledge lands on the tick the timeout would fire.
      step = 1'b1;
      tick();
      checks++; if (err !== 1'b1 || sent !== 1'b1 || data !== 8'h40) begin failures++; $display("[TB] FAIL to_retry got=%b/%b/%h exp=1/1/40", err, sent, data); end
      tick();
      tick();
      received_drv = 1'b1;
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL to_ack_err got=%b exp=0", err); end
      checks++; if (sent !== 1'b0 || count !== 16'd1) begin failures++; $display("[TB] FAIL to_ack got=%b/%0d exp=0/1", sent, count); end
      step = 1'b0;
      received_drv = 1'b0;
      tick();
      checks++; if (data !== 8'h41) begin failures++; $display("[TB] FAIL to_next_data got=%h exp=41", data); end
   endtask

   task automatic test_auto();
      do_reset();
      mode = MODE_INC;
      loopback = 1'b1;
      auto_en = 1'b1;
      step = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (sent !== 1'b1) begin failures++; $display("[TB] FAIL auto_sent[%0d] got=%b exp=1", k, sent); end
         checks++; if (data !== 8'(8'h40 + k)) begin failures++; $display("[TB] FAIL auto_data[%0d] got=%h exp=%h", k, data, 8'(8'h40 + k)); end
         checks++; if (count !== 16'(k)) begin failures++; $display("[TB] FAIL auto_count[%0d] got=%0d exp=%0d", k, count, k); end
         step = ~step;
         tick();
         tick();
      end
      checks++; if (count !== 16'd4 || data !== 8'h44) begin failures++; $display("[TB] FAIL auto_final got=%0d/%h exp=4/44", count, data); end
   endtask

   task automatic test_reset_mid();
      loopback = 1'b0;
      received_drv = 1'b0;
      tick();
      checks++; if (sent !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_sent got=%b exp=1", sent); end
      repeat (2) @(posedge clk_raw);
      #1;
      reset = 1'b1;
      @(posedge clk_raw);
      #1;
      checks++; if (sent !== 1'b0) begin failures++; $display("[TB] FAIL mid_sent got=%b exp=0", sent); end
      checks++; if (data !== 8'h40) begin failures++; $display("[TB] FAIL mid_data got=%h exp=40", data); end
      checks++; if (count !== 16'd0) begin failures++; $display("[TB] FAIL mid_count got=%0d exp=0", count); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy got=%b exp=0", busy); end
      checks++; if (dut.state !== WAIT_REQ) begin failures++; $display("[TB] FAIL mid_state got=%0d exp=%0d", dut.state, WAIT_REQ); end
      reset = 1'b0;
      auto_en = 1'b0;
      step = 1'b0;
      tick();
      checks++; if (sent !== 1'b0) begin failures++; $display("[TB] FAIL mid_after_sent got=%b exp=0", sent); end
   endtask

   initial begin
      $display("[TB] pattern_sequencer directed test start");
      test_reset();
      test_single_step();
      test_held_step();
      test_modes();
      test_timeout();
      test_auto();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Parametrised successor to our push-button byte stepper that feeds a parallel-input transmitter over a sent/received handshake.
- Generates a data word per request, presents it with `sent`, and waits for `received`.
- Advances the word by a selectable mode: increment, decrement, walking-one or constant.
- Adds free-running auto mode, an acknowledge timeout with error flag, and a transfer counter.
- Sits between the single-pulsed button logic and the UART transmit block.

Parameters:
- WIDTH, 8, data word width in bits (2..16).
- START, 8'h40, value loaded into the data word on reset (truncated or zero-extended to WIDTH).
- TICK_DIV, 1160, clk_raw cycles per FSM tick. Must be at least 1.
- TIMEOUT, 255, FSM ticks allowed in SEND before abort. A value of 0 disables the timeout.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk_raw  in  1  system clock; all logic is clocked on its rising edge.
- reset  in  1  synchronous, active-high reset.
- step  in  1  request level from a single-pulser. Held high while the button is down.
- auto_en  in  1  when 1, requests are generated internally and `step` is ignored.
- mode  in  2  word update rule: 0 inc, 1 dec, 2 walking-one (rotate left), 3 constant.
- received  in  1  acknowledge from the transmitter.
- data  out  WIDTH  current word. Stable from SEND entry until RELEASE exit.
- sent  out  1  request to the transmitter.
- busy  out  1  high in SEND and RELEASE.
- err  out  1  sticky timeout flag. Cleared by reset or by the next successful acknowledge.
- count  out  CNT_W  number of acknowledged transfers, wrapping.

Behaviour:
- Tick generation:
  - A divider counts 0..TICK_DIV-1 on clk_raw; `tick` is high for one cycle at the terminal count.
  - The FSM evaluates only on cycles where tick=1. All other registers hold between ticks.
- Reset (synchronous, any state, including mid-handshake):
  - data=START, sent=0, busy=0, err=0, count=0, divider=0, timeout counter=0.
  - FSM goes to WAIT_REQ.
- WAIT_REQ:
  - req = auto_en ? 1 : step.
  - If req=1: go to SEND and set sent=1.
- SEND:
  - sent=1, data frozen.
  - If received=1: set sent=0, count+=1, err=0, go to RELEASE.
  - Otherwise, if TIMEOUT≠0 and the timeout counter reaches TIMEOUT-1: set sent=0, err=1, go to WAIT_REQ. The word is not advanced and the same word is retried on the next request.
  - The timeout counter increments each tick in SEND and clears on SEND exit.
- RELEASE:
  - Exit condition: (auto_en=1 or step=0) and received=0. This blocks double-sends on a held button and a stuck acknowledge.
  - On exit, update the data word, then go to WAIT_REQ:
    - inc: data+1, wrapping from all-ones to 0.
    - dec: data-1, wrapping from 0 to all-ones.
    - walking-one: if data has exactly one bit set, rotate left by 1 (MSB wraps to LSB). Otherwise load 1.
    - constant: data unchanged.
  - mode is sampled only at the RELEASE exit tick. A mode change mid-transfer takes effect for the next word.
- Simultaneous events:
  - received=1 on the same tick that the timeout would expire: the acknowledge wins, err=0.
  - auto_en changing in SEND is ignored until RELEASE.
- Outputs are registered. `sent` rises one clk_raw cycle after the tick that enters SEND.
- count wraps from 2^CNT_W-1 to 0.
- The state encoding has an unused code, which recovers to WAIT_REQ on the next tick.

Decomposition:
- Shared package holds:
  - the state encoding (WAIT_REQ, SEND, RELEASE);
  - the mode constants (MODE_INC=0, MODE_DEC=1, MODE_WALK=2, MODE_CONST=3).
- One sub-module: tick_divider, parameter TICK_DIV, ports clk_raw, reset, tick. It is reusable by the UART clock logic.

Test Plan (TICK_DIV=4, TIMEOUT=3, WIDTH=8):
- Reset, then pulse step high for 4 ticks with received tied to sent after 2 ticks:
  - data=0x40, sent rises once, count=1.
  - After step falls, data=0x41.
- step held high across 3 acknowledges:
  - exactly one transfer occurs.
  - the second transfer starts only after step=0 and then step=1.
- mode=1 starting from START=0x00:
  - one transfer gives data=0xFF.
  - mode=2 with data=0x80 gives 0x01; mode=2 with data=0x41 gives 0x01.
- received never asserted, step pulsed:
  - after 3 ticks in SEND, sent=0 and err=1, data is unchanged, count is unchanged.
  - the next acknowledged request clears err.
- auto_en=1 with an immediate acknowledge:
  - continuous transfers 0x40, 0x41, 0x42…
  - count increments once per word, and step toggling has no effect.
- reset asserted while sent=1:
  - next clk_raw cycle: sent=0, data=0x40, count=0, FSM in WAIT_REQ.
